// File: rtl/lc3_regfile_mp.sv
// LC-3 general-purpose register file: one write port, two registered read ports
// with optional write-to-read bypass, plus the architectural NZP condition codes.
module lc3_regfile_mp #(
  parameter int                DATA_W   = 16,
  parameter int                NUM_REGS = 8,
  parameter int                ADDR_W   = 3,
  parameter int                BYPASS   = 1,
  parameter int                SP_IDX   = 6,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(16'h3000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ld_cc,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic [2:0]        nzp
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  logic signed [DATA_W-1:0] regs_q [NUM_REGS];
  logic signed [DATA_W-1:0] wdata_s;
  logic signed [DATA_W-1:0] rd1_next, rd2_next;
  logic signed [DATA_W-1:0] rd1_data_p1, rd2_data_p1;
  logic [2:0]               nzp_p1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_L;
  endfunction

  function automatic logic [2:0] cc_decode(input logic signed [DATA_W-1:0] v);
    if (v < 0)       return 3'b100;
    else if (v == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  assign wdata_s = $signed(wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == SP_IDX) ? $signed(SP_RESET) : '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (waddr == i[ADDR_W-1:0]) regs_q[i] <= wdata_s;
    end
  end

  // Out-of-range addresses match no entry and therefore read as zero.
  always_comb begin
    rd1_next = '0;
    rd2_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd1_addr == i[ADDR_W-1:0]) rd1_next = regs_q[i];
      if (rd2_addr == i[ADDR_W-1:0]) rd2_next = regs_q[i];
    end
    if (BYPASS != 0 && we && in_range(waddr)) begin
      if (waddr == rd1_addr) rd1_next = wdata_s;
      if (waddr == rd2_addr) rd2_next = wdata_s;
    end
  end

  // p0 -> p1: read capture and condition-code update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_data_p1 <= '0;
      rd2_data_p1 <= '0;
      nzp_p1      <= 3'b010;
    end else begin
      if (rd1_en)      rd1_data_p1 <= rd1_next;
      if (rd2_en)      rd2_data_p1 <= rd2_next;
      if (we && ld_cc) nzp_p1      <= cc_decode(wdata_s);
    end
  end

  assign rd1_data = rd1_data_p1;
  assign rd2_data = rd2_data_p1;
  assign nzp      = nzp_p1;

endmodule

// File: tb/tb_lc3_regfile_mp.sv
// Bench for lc3_regfile_mp: three variants (bypass, no bypass, 6 registers) driven
// by the same stimulus and compared each cycle against an array-based reference.
module tb_lc3_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        we = 1'b0, ld_cc = 1'b0, rd1_en = 1'b0, rd2_en = 1'b0;
  logic [2:0]  waddr = '0, rd1_addr = '0, rd2_addr = '0;
  logic [15:0] wdata = '0;

  logic [15:0] rd1_o [3];
  logic [15:0] rd2_o [3];
  logic [2:0]  nzp_o [3];

  lc3_regfile_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .ld_cc(ld_cc),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_o[0]),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_o[0]), .nzp(nzp_o[0]));

  lc3_regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .ld_cc(ld_cc),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_o[1]),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_o[1]), .nzp(nzp_o[1]));

  lc3_regfile_mp #(.NUM_REGS(6)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .ld_cc(ld_cc),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_o[2]),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_o[2]), .nzp(nzp_o[2]));

  // Reference model: per-variant register contents and expected outputs.
  int          nregs [3] = '{8, 8, 6};
  int          byp   [3] = '{1, 0, 1};
  logic [15:0] m     [3][8];
  logic [15:0] e_rd1 [3];
  logic [15:0] e_rd2 [3];
  logic [2:0]  e_nzp [3];

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++)
        m[k][r] = (r == 6 && r < nregs[k]) ? 16'h3000 : 16'h0000;
      e_rd1[k] = 16'h0000;
      e_rd2[k] = 16'h0000;
      e_nzp[k] = 3'b010;
    end
  endtask

  function automatic logic [15:0] rd_val(int k, logic [2:0] a);
    if (int'(a) >= nregs[k]) return 16'h0000;
    if (byp[k] != 0 && we && waddr == a) return wdata;
    return m[k][a];
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rd1_en) e_rd1[k] = rd_val(k, rd1_addr);
      if (rd2_en) e_rd2[k] = rd_val(k, rd2_addr);
      if (we && ld_cc)
        e_nzp[k] = wdata[15] ? 3'b100 : (wdata == 16'h0000 ? 3'b010 : 3'b001);
      if (we && int'(waddr) < nregs[k]) m[k][waddr] = wdata;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s/u%0d/rd1", tag, k), rd1_o[k], e_rd1[k]);
      chk($sformatf("%s/u%0d/rd2", tag, k), rd2_o[k], e_rd2[k]);
      chk($sformatf("%s/u%0d/nzp", tag, k), {13'b0, nzp_o[k]}, {13'b0, e_nzp[k]});
    end
  endtask

  task automatic cycle(input string tag);
    if (rst_n) model_step();
    else       model_reset();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                     input logic c, input logic e1, input logic [2:0] a1,
                     input logic e2, input logic [2:0] a2);
    we = w; waddr = wa; wdata = wd; ld_cc = c;
    rd1_en = e1; rd1_addr = a1; rd2_en = e2; rd2_addr = a2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
      cycle("rd_all");
    end

    set(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0); cycle("wr_r3");
    set(1'b0, 3'd0, 16'h0,    1'b0, 1'b1, 3'd3, 1'b1, 3'd0); cycle("rd_r3_r0");
    chk("r3_const", rd1_o[0], 16'hBEEF);

    set(1'b1, 3'd5, 16'h1234, 1'b0, 1'b1, 3'd5, 1'b1, 3'd5); cycle("same_cyc_r5");
    chk("bypass_on", rd2_o[0], 16'h1234);
    chk("bypass_off", rd2_o[1], 16'h0000);
    set(1'b0, 3'd0, 16'h0,    1'b0, 1'b1, 3'd5, 1'b1, 3'd5); cycle("after_r5");
    chk("after_r5_const", rd1_o[1], 16'h1234);

    set(1'b1, 3'd1, 16'h8000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0); cycle("nzp_neg");
    chk("nzp_neg_const", {13'b0, nzp_o[0]}, 16'd4);
    set(1'b1, 3'd2, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0); cycle("nzp_zero");
    set(1'b1, 3'd2, 16'h0001, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0); cycle("nzp_pos");
    set(1'b1, 3'd4, 16'h8000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0); cycle("nzp_no_ld");
    set(1'b0, 3'd4, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0); cycle("nzp_no_we");
    chk("nzp_hold_const", {13'b0, nzp_o[0]}, 16'd1);

    set(1'b1, 3'd7, 16'hA5A5, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0); cycle("wr_a7");
    set(1'b1, 3'd6, 16'h5A5A, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0); cycle("wr_a6");
    set(1'b0, 3'd0, 16'h0,    1'b0, 1'b1, 3'd7, 1'b1, 3'd6); cycle("rd_a7_a6");
    chk("oor_rd7", rd1_o[2], 16'h0000);
    for (int i = 0; i < 6; i++) begin
      set(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'(i), 1'b1, 3'(5 - i));
      cycle("rd_small");
    end

    set(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0); cycle("hold_load");
    for (int i = 0; i < 5; i++) begin
      set(1'b1, 3'(i + 1), 16'(i * 16'h0101), 1'b0, 1'b0, 3'(i), 1'b1, 3'(i));
      cycle("hold");
    end
    chk("hold_const", rd1_o[0], 16'hBEEF);

    repeat (400) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = 16'h8000 | 16'($urandom);
        default: d = 16'($urandom);
      endcase
      set(1'($urandom), 3'($urandom), d, 1'($urandom),
          1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
      cycle("rand");
    end

    set(1'b1, 3'd1, 16'h1111, 1'b0, 1'b1, 3'd2, 1'b1, 3'd4); cycle("b2b_1");
    set(1'b1, 3'd1, 16'h2222, 1'b1, 1'b1, 3'd1, 1'b1, 3'd1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    cycle("in_rst");
    rst_n = 1'b1;
    set(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd6); cycle("post_rst");
    chk("post_rst_r1", rd1_o[0], 16'h0000);
    chk("post_rst_sp", rd2_o[0], 16'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
